// File: rtl/wb_gpio.sv
// -----------------------------------------------------------------------------
// wb_gpio -- Wishbone slave GPIO block with debounced inputs and interrupts.
//
// Nine inputs (four slide switches and five active-low push buttons) are
// synchronised, debounced on a slow sample tick and exposed as a read-only
// register. Any debounced edge latches a pending bit. The pending bits,
// masked by an enable register, form a level interrupt. Four LEDs are driven
// from a read/write register.
//
// Parameters
//   clk_freq  system clock frequency in Hz (informational only)
//   db_max    debounce sample period in clk cycles, 2 .. 2^24-1
//
// Ports
//   clk       system clock, all state on the rising edge
//   reset_n   asynchronous active-low reset
//   wb_adr_i  Wishbone address, only [3:2] decoded
//   wb_dat_i  Wishbone write data
//   wb_dat_o  Wishbone read data, non-zero only while wb_ack_o is high
//   wb_sel_i  byte-lane select, lane 0 -> bits [7:0], lane 1 -> bit 8
//   wb_stb_i  Wishbone strobe
//   wb_cyc_i  Wishbone cycle
//   wb_we_i   Wishbone write enable
//   wb_ack_o  Wishbone acknowledge
//   btn_n     push buttons, active-low, asynchronous
//   sw        slide switches, active-high, asynchronous
//   led_n     LEDs, active-low
//   intr      level interrupt, active-high
//
// Register map (word index wb_adr_i[3:2])
//   0 IN        read-only   debounced inputs in [8:0] = {sw, buttons}
//   1 OUT       read/write  LED state in [3:0]
//   2 IRQ_EN    read/write  interrupt enables in [8:0]
//   3 IRQ_PEND  read, write-1-to-clear, pending edges in [8:0]
// -----------------------------------------------------------------------------
module wb_gpio #(
   parameter int unsigned clk_freq = 100000000,
   parameter int unsigned db_max   = 1000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   input  logic        wb_we_i,
   output logic        wb_ack_o,
   input  logic [4:0]  btn_n,
   input  logic [3:0]  sw,
   output logic [3:0]  led_n,
   output logic        intr
);

   localparam int unsigned   N_IN       = 9;
   localparam int unsigned   PRESC_W    = 24;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(db_max - 1);

   typedef enum logic [1:0] {
      REG_IN       = 2'd0,
      REG_OUT      = 2'd1,
      REG_IRQ_EN   = 2'd2,
      REG_IRQ_PEND = 2'd3
   } reg_idx_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [N_IN-1:0]    sync1_q, sync1_d;
   logic [N_IN-1:0]    sync2_q, sync2_d;
   logic [N_IN-1:0]    samp_q, samp_d;
   logic [N_IN-1:0]    deb_q, deb_d;
   logic [N_IN-1:0]    deb_prev_q, deb_prev_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [3:0]         led_q, led_d;
   logic [N_IN-1:0]    irq_en_q, irq_en_d;
   logic [N_IN-1:0]    pend_q, pend_d;
   logic               intr_q, intr_d;
   logic               ack_q, ack_d;
   logic [31:0]        dat_q, dat_d;

   // ---------------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------------
   logic [N_IN-1:0] in_raw;
   logic            tick;
   logic [N_IN-1:0] stable;
   logic            access;
   logic            wr;
   reg_idx_e        reg_idx;
   logic [N_IN-1:0] lane_mask;
   logic [N_IN-1:0] wdat;
   logic [N_IN-1:0] clr;
   logic [31:0]     rdata;

   // Address bits outside [3:2], upper data bits and lanes 2/3 carry no
   // meaning here; clk_freq is documentation only.
   logic unused_ok;
   assign unused_ok = &{1'b0, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:9],
                        wb_sel_i[3:2], (clk_freq != 0)};

   // Buttons are inverted so a pressed button reads as 1.
   assign in_raw = {sw, ~btn_n};

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the block leaves a value unassigned and no latch is inferred.
      sync1_d    = in_raw;
      sync2_d    = sync1_q;
      presc_d    = presc_q;
      samp_d     = samp_q;
      deb_d      = deb_q;
      deb_prev_d = deb_q;
      led_d      = led_q;
      irq_en_d   = irq_en_q;
      clr        = '0;
      rdata      = '0;

      // Sample-period prescaler: tick marks the last count before wrapping.
      tick = (presc_q == PRESC_LAST);
      if (tick) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + 1'b1;
      end

      // A bit is accepted only when two consecutive ticks agree on it, so a
      // glitch seen by at most one tick never reaches deb.
      stable = ~(samp_q ^ sync2_q);
      if (tick) begin
         samp_d = sync2_q;
         deb_d  = (deb_q & ~stable) | (sync2_q & stable);
      end

      // Wishbone: ack is raised for one cycle per request, so a held strobe
      // is acknowledged on every other edge. The write lands on the same edge
      // that raises ack.
      access    = wb_stb_i & wb_cyc_i & ~ack_q;
      wr        = access & wb_we_i;
      reg_idx   = reg_idx_e'(wb_adr_i[3:2]);
      lane_mask = {wb_sel_i[1], {8{wb_sel_i[0]}}};
      wdat      = wb_dat_i[N_IN-1:0];

      case (reg_idx)
         REG_IN:       rdata = {23'h0, deb_q};
         REG_OUT:      rdata = {28'h0, led_q};
         REG_IRQ_EN:   rdata = {23'h0, irq_en_q};
         REG_IRQ_PEND: rdata = {23'h0, pend_q};
         default:      rdata = '0;
      endcase

      if (wr) begin
         case (reg_idx)
            REG_OUT: begin
               if (wb_sel_i[0]) begin
                  led_d = wb_dat_i[3:0];
               end
            end
            REG_IRQ_EN:   irq_en_d = (irq_en_q & ~lane_mask) | (wdat & lane_mask);
            REG_IRQ_PEND: clr = wdat & lane_mask;
            default:      ;  // IN is read-only
         endcase
      end

      // deb_prev holds last cycle's deb, so an edge sets pend one cycle after
      // deb moves. OR-ing the set term last makes set win over a same-cycle
      // clear.
      pend_d = (pend_q & ~clr) | (deb_q ^ deb_prev_q);

      intr_d = |(pend_q & irq_en_q);
      ack_d  = access;
      dat_d  = access ? rdata : 32'h0;
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         samp_q     <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         presc_q    <= '0;
         led_q      <= '0;
         irq_en_q   <= '0;
         pend_q     <= '0;
         intr_q     <= 1'b0;
         ack_q      <= 1'b0;
         dat_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the values
         // from before the edge, independent of statement order.
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         samp_q     <= samp_d;
         deb_q      <= deb_d;
         deb_prev_q <= deb_prev_d;
         presc_q    <= presc_d;
         led_q      <= led_d;
         irq_en_q   <= irq_en_d;
         pend_q     <= pend_d;
         intr_q     <= intr_d;
         ack_q      <= ack_d;
         dat_q      <= dat_d;
      end
   end

   // Every output comes straight from a flop (led_n through an inverter only).
   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;
   assign led_n    = ~led_q;
   assign intr     = intr_q;

endmodule

// File: tb/tb_wb_gpio.sv
// -----------------------------------------------------------------------------
// tb_wb_gpio -- self-checking bench for wb_gpio with db_max = 4.
// Directed scenarios for reset, LEDs, debounce, interrupts, set/clear
// collision and back-to-back strobes, followed by randomized traffic. A
// behavioural model follows the block cycle by cycle and every visible output
// is compared against it on each falling edge.
// -----------------------------------------------------------------------------
module tb_wb_gpio;

   localparam int unsigned DB = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_i = '0;
   logic        wb_stb_i = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_we_i = 1'b0;
   logic        wb_ack_o;
   logic [4:0]  btn_n = 5'h1F;
   logic [3:0]  sw = 4'h0;
   logic [3:0]  led_n;
   logic        intr;

   wb_gpio #(.clk_freq(100000000), .db_max(DB)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_sel_i (wb_sel_i),
      .wb_stb_i (wb_stb_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_we_i  (wb_we_i),
      .wb_ack_o (wb_ack_o),
      .btn_n    (btn_n),
      .sw       (sw),
      .led_n    (led_n),
      .intr     (intr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int last_ack_cyc = 0;
   bit mon_en   = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: sync = input seen two edges ago; a tick every DB-th edge
   // after reset; a bit is accepted when two ticks agree; an accepted change
   // marks the bit pending one edge later; intr follows pend & en one edge late.
   // ---------------------------------------------------------------------------
   logic [8:0]  m_hist[$];
   logic [8:0]  m_samp, m_deb, m_changed, m_en, m_pend;
   logic [3:0]  m_led;
   logic        m_intr, m_ack;
   logic [31:0] m_dat;
   int unsigned m_edges;

   task automatic model_reset();
      m_hist    = '{9'h0, 9'h0};
      m_samp    = '0;
      m_deb     = '0;
      m_changed = '0;
      m_en      = '0;
      m_pend    = '0;
      m_led     = '0;
      m_intr    = 1'b0;
      m_ack     = 1'b0;
      m_dat     = '0;
      m_edges   = 0;
   endtask

   task automatic model_step();
      logic [8:0]  in_now, sync, mask, clr, pend_old, en_old, deb_old;
      logic [31:0] rd;
      logic [1:0]  idx;
      bit          tick, acc, wr;
      if (!reset_n) begin
         model_reset();
         return;
      end
      in_now   = {sw, ~btn_n};
      sync     = m_hist[1];
      tick     = (m_edges % DB) == DB - 1;
      pend_old = m_pend;
      en_old   = m_en;
      deb_old  = m_deb;

      acc  = wb_stb_i && wb_cyc_i && !m_ack;
      wr   = acc && wb_we_i;
      idx  = wb_adr_i[3:2];
      mask = {wb_sel_i[1], {8{wb_sel_i[0]}}};
      case (idx)
         2'd0:    rd = {23'h0, m_deb};
         2'd1:    rd = {28'h0, m_led};
         2'd2:    rd = {23'h0, m_en};
         default: rd = {23'h0, m_pend};
      endcase
      m_dat = acc ? rd : 32'h0;
      m_ack = acc;
      clr   = '0;
      if (wr) begin
         case (idx)
            2'd1: if (wb_sel_i[0]) m_led = wb_dat_i[3:0];
            2'd2: m_en = (m_en & ~mask) | (wb_dat_i[8:0] & mask);
            2'd3: clr = wb_dat_i[8:0] & mask;
            default: ;
         endcase
      end
      m_pend = (pend_old & ~clr) | m_changed;
      m_intr = |(pend_old & en_old);

      if (tick) begin
         for (int i = 0; i < 9; i++) begin
            if (m_samp[i] == sync[i]) m_deb[i] = sync[i];
         end
         m_samp = sync;
      end
      m_changed = m_deb ^ deb_old;

      m_hist.push_front(in_now);
      void'(m_hist.pop_back());
      m_edges++;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         model_step();
      end
   end

   // Per-cycle comparison of all outputs against the model.
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         check("mon_led_n", {28'h0, led_n}, {28'h0, ~m_led});
         check("mon_intr", {31'h0, intr}, {31'h0, m_intr});
         check("mon_ack", {31'h0, wb_ack_o}, {31'h0, m_ack});
         check("mon_dat_o", wb_dat_o, m_dat);
      end
   end

   // ---------------------------------------------------------------------------
   // Bus tasks. wb_xfer drives immediately (caller sits on a falling edge).
   // ---------------------------------------------------------------------------
   task automatic wb_xfer(input logic we, input logic [1:0] idx, input logic [31:0] d,
                          input logic [3:0] sel, output logic [31:0] rd, output int waited);
      wb_adr_i = {28'h0, idx, 2'b00};
      wb_dat_i = d;
      wb_sel_i = sel;
      wb_we_i  = we;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      waited   = 0;
      rd       = '0;
      do begin
         @(posedge clk);
         #1;
         waited++;
      end while (!wb_ack_o && waited < 8);
      if (wb_ack_o) begin
         rd = wb_dat_o;
         last_ack_cyc = cyc;
      end
      check("ack_wait", waited, 1);
      @(negedge clk);
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic wb_write(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] sel);
      logic [31:0] rd;
      int w;
      @(negedge clk);
      wb_xfer(1'b1, idx, d, sel, rd, w);
   endtask

   task automatic wb_read(input logic [1:0] idx, output logic [31:0] rd);
      int w;
      @(negedge clk);
      wb_xfer(1'b0, idx, 32'h0, 4'hF, rd, w);
   endtask

   // Watchdog: a hang is reported and the run stops.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [31:0] rd;
      int          w, c0, n_ack;
      bit          found;

      // Reset state, buttons released and switches low.
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      check("rst_led_n", {28'h0, led_n}, 32'hF);
      check("rst_intr", {31'h0, intr}, 32'h0);
      check("rst_ack", {31'h0, wb_ack_o}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      wb_read(2'd0, rd);
      check("rst_in_read", rd, 32'h0);

      // LED register, full and empty lane selects.
      wb_write(2'd1, 32'h5, 4'hF);
      check("led_n_after_write", {28'h0, led_n}, 32'hA);
      wb_read(2'd1, rd);
      check("out_read", rd, 32'h5);
      wb_write(2'd1, 32'hF, 4'h0);
      wb_read(2'd1, rd);
      check("out_sel0_ignored", rd, 32'h5);
      wb_write(2'd0, 32'h1FF, 4'hF);
      wb_read(2'd0, rd);
      check("in_write_no_effect", rd, 32'h0);

      // Short glitch on button 2 is filtered out.
      @(negedge clk);
      btn_n = 5'h1B;
      repeat (2) @(negedge clk);
      btn_n = 5'h1F;
      repeat (16) @(negedge clk);
      wb_read(2'd0, rd);
      check("glitch_in", rd, 32'h0);
      wb_read(2'd3, rd);
      check("glitch_pend", rd, 32'h0);

      // Held button 2 appears within the debounce bound.
      @(negedge clk);
      btn_n = 5'h1B;
      c0 = cyc;
      rd = '0;
      for (int i = 0; i < 10; i++) begin
         wb_read(2'd0, rd);
         if (rd == 32'h4) break;
      end
      check("deb_in_held", rd, 32'h4);
      check("deb_latency_ok", {31'h0, (last_ack_cyc - c0) <= 12}, 32'h1);
      while (cyc - c0 < 20) @(negedge clk);
      btn_n = 5'h1F;
      repeat (14) @(negedge clk);

      // Interrupt on press, clear, and again on release.
      wb_write(2'd3, 32'h1FF, 4'h3);
      wb_read(2'd3, rd);
      check("pend_cleared", rd, 32'h0);
      wb_write(2'd2, 32'h4, 4'h3);
      wb_read(2'd2, rd);
      check("irq_en_read", rd, 32'h4);
      check("intr_idle", {31'h0, intr}, 32'h0);
      btn_n = 5'h1B;
      for (int i = 0; i < 20 && !intr; i++) @(negedge clk);
      check("intr_on_press", {31'h0, intr}, 32'h1);
      wb_read(2'd3, rd);
      check("pend_on_press", rd, 32'h4);
      wb_write(2'd3, 32'h4, 4'h1);
      @(negedge clk);
      check("intr_cleared", {31'h0, intr}, 32'h0);
      btn_n = 5'h1F;
      for (int i = 0; i < 20 && !intr; i++) @(negedge clk);
      check("intr_on_release", {31'h0, intr}, 32'h1);
      wb_write(2'd3, 32'h1FF, 4'h3);
      wb_write(2'd2, 32'h0, 4'h3);

      // Set/clear collision on pend[5] (sw[0]).
      @(negedge clk);
      sw = 4'h1;
      repeat (14) @(negedge clk);
      wb_write(2'd3, 32'h20, 4'h1);
      sw = 4'h0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_changed[5]) begin
            found = 1'b1;
            break;
         end
      end
      check("collision_window", {31'h0, found}, 32'h1);
      if (found) wb_xfer(1'b1, 2'd3, 32'h20, 4'h1, rd, w);
      wb_read(2'd3, rd);
      check("collision_set_wins", {31'h0, rd[5]}, 32'h1);
      wb_write(2'd3, 32'h20, 4'h1);
      wb_read(2'd3, rd);
      check("w1c_clears", {31'h0, rd[5]}, 32'h0);

      // Sustained strobe: one ack every other cycle.
      @(negedge clk);
      wb_adr_i = 32'h0;
      wb_we_i  = 1'b0;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      n_ack = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (wb_ack_o) n_ack++;
      end
      @(negedge clk);
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      check("b2b_ack_count", n_ack, 3);

      // Reset in the middle of a write aborts it.
      wb_write(2'd1, 32'h5, 4'hF);
      wb_write(2'd2, 32'h1FF, 4'h3);
      @(negedge clk);
      wb_adr_i = 32'h4;
      wb_dat_i = 32'hC;
      wb_sel_i = 4'hF;
      wb_we_i  = 1'b1;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_ack", {31'h0, wb_ack_o}, 32'h0);
      check("midrst_led_n", {28'h0, led_n}, 32'hF);
      @(negedge clk);
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i  = 1'b0;
      reset_n  = 1'b1;
      wb_read(2'd1, rd);
      check("midrst_out", rd, 32'h0);
      wb_read(2'd2, rd);
      check("midrst_irq_en", rd, 32'h0);
      wb_read(2'd3, rd);
      check("midrst_pend", rd, 32'h0);

      // Button held through reset raises pend after reset.
      @(negedge clk);
      btn_n   = 5'h1E;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (14) @(negedge clk);
      wb_read(2'd0, rd);
      check("held_rst_in", rd, 32'h1);
      wb_read(2'd3, rd);
      check("held_rst_pend", rd, 32'h1);
      btn_n = 5'h1F;

      // Randomized traffic, checked every cycle by the monitor.
      for (int it = 0; it < 150; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            btn_n = 5'($urandom);
            sw    = 4'($urandom);
            repeat ($urandom_range(0, 12)) @(negedge clk);
         end else begin
            @(negedge clk);
            wb_xfer(1'($urandom), 2'($urandom), $urandom, 4'($urandom), rd, w);
         end
      end

      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/wb_gpio.md
WB_GPIO -- requirements
Module: wb_gpio

Interface
REQ-001 Parameter clk_freq, default 100000000: system clock frequency in Hz, informational only.
REQ-002 Parameter db_max, default 1000000: debounce sample period in clk cycles, 10 ms at 100 MHz; legal range 2..2^24-1.
REQ-003 clk  input  1  system clock; all state rising-edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 wb_adr_i  input  32  Wishbone address; only bits [3:2] are decoded.
REQ-006 wb_dat_i  input  32  Wishbone write data.
REQ-007 wb_dat_o  output  32  Wishbone read data.
REQ-008 wb_sel_i  input  4  byte-lane select.
REQ-009 wb_stb_i, wb_cyc_i, wb_we_i  input  1 each  Wishbone strobe, cycle and write enable.
REQ-010 wb_ack_o  output  1  Wishbone acknowledge.
REQ-011 btn_n  input  5  asynchronous push buttons, active-low.
REQ-012 sw  input  4  asynchronous slide switches, active-high.
REQ-013 led_n  output  4  LEDs, active-low.
REQ-014 intr  output  1  level interrupt, active-high, to the lm32 interrupt vector.

Function
REQ-015 Raw vector in[8:0] SHALL be {sw[3:0], ~btn_n[4:0]}, so a pressed button reads as 1.
REQ-016 Each in bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-017 Prescaler SHALL count 0..db_max-1 and wrap to 0; tick is 1 for the single cycle in which count == db_max-1.
REQ-018 On each tick:
- samp <= sync.
- For each bit where samp == sync, deb SHALL load sync.
- Other deb bits hold.
REQ-019 A clean input change SHALL appear in deb within 2*db_max+3 cycles.
REQ-020 A pulse shorter than db_max cycles that is seen by at most one tick SHALL NOT change deb.
REQ-021 Register map, word index wb_adr_i[3:2]:
- 0 IN: read-only, deb[8:0] in bits [8:0].
- 1 OUT: read/write, led[3:0].
- 2 IRQ_EN: read/write, [8:0].
- 3 IRQ_PEND: read, write-1-to-clear, [8:0].
- All unused read bits SHALL be 0.
REQ-022 led_n SHALL equal ~led.
REQ-023 pend[i] SHALL set in the cycle after deb[i] changes value, in either direction.
REQ-024 If a pend set and a W1C clear of the same bit coincide, set SHALL win.
REQ-025 intr SHALL be the OR over all bits of (pend & irq_en), registered, so it lags pend and irq_en changes by 1 cycle.
REQ-026 Write byte-lane gating:
- wb_sel_i[0] gates bits [7:0].
- wb_sel_i[1] gates bit 8.
- Lanes 2 and 3 are ignored.
- A write to IN SHALL have no effect.
REQ-027 Handshake:
- wb_ack_o <= wb_stb_i & wb_cyc_i & ~wb_ack_o.
- The write takes effect on the same edge that raises ack.
- wb_dat_o is valid while ack is 1 and is 0 otherwise.
REQ-028 A sustained strobe SHALL be acknowledged every other cycle.
REQ-029 Dropping wb_stb_i or wb_cyc_i before ack SHALL cause no register side effect.
REQ-030 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-031 While reset_n = 0, asynchronously:
- sync, samp, deb, prescaler, led, irq_en, pend and intr SHALL be 0.
- wb_ack_o = 0, wb_dat_o = 0, led_n = 4'hF.
REQ-032 Deassertion SHALL take effect on the first clk edge after reset_n rises.
REQ-033 Reset asserted mid-transaction SHALL abort it with no ack and no register write.
REQ-034 Buttons held during reset SHALL set pend once their deb bit goes to 1 after reset.

Verification (db_max = 4 in the bench)
REQ-035 Reset check: reset_n = 0 with btn_n = 5'h1F and sw = 0 -> led_n = 4'hF, intr = 0, and a read of IN returns 0.
REQ-036 LED write: write OUT = 32'h5 with sel = 4'hF -> ack 1 cycle later, led_n = 4'hA, read of OUT returns 5; a write with sel = 4'h0 -> led unchanged.
REQ-037 Debounce: drive btn_n[2] = 0 for 2 cycles, then release -> IN stays 0. Hold btn_n[2] = 0 for 20 cycles -> IN = 9'h004 within 11 cycles of assertion.
REQ-038 Interrupt: IRQ_EN = 9'h004, press btn 2 -> pend[2] = 1 and intr = 1 one cycle later. Write IRQ_PEND = 9'h004 -> intr = 0. Release -> intr = 1 again.
REQ-039 Set/clear collision: issue a W1C of pend[5] in the same cycle deb[5] toggles -> pend[5] remains 1.
REQ-040 Back-to-back strobe: hold stb and cyc for 6 cycles -> exactly 3 single-cycle acks; a reset pulse mid-cycle -> ack = 0 and registers = 0.
